// File: rtl/rv32m_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: funct3 codes,
// FSM state encoding, shift-core step modes and operand decode helpers.
package rv32m_pkg;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'd0,
    MODE_LOAD = 2'd1,
    MODE_MUL  = 2'd2,
    MODE_DIV  = 2'd3
  } core_mode_t;

  // All divide/remainder ops have funct3[2] set.
  function automatic logic is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

  // Whether operand A (operand_b=0) or operand B (operand_b=1) is read as signed.
  // MUL only needs the low half, so it runs on raw unsigned bit patterns.
  function automatic logic is_signed(input logic [2:0] f3, input logic operand_b);
    case (f3)
      F3_MULH, F3_DIV, F3_REM: return 1'b1;
      F3_MULHSU:               return !operand_b;
      default:                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mdu_shift_core.sv
// Shared datapath: 2N-bit accumulator plus N-bit operand register.
// Multiply: shift-add, LSB of the multiplier first, product builds in the upper half.
// Divide: restoring, remainder in the upper half, quotient shifts into the lower half.
module mdu_shift_core
  import rv32m_pkg::*;
#(
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  core_mode_t     mode,
  input  logic [N-1:0]   load_a,
  input  logic [N-1:0]   load_b,
  output logic [2*N-1:0] acc
);

  logic [2*N-1:0] acc_q, acc_d;
  logic [N-1:0]   op_q;
  logic [N:0]     mul_sum;
  logic [N:0]     div_rem;
  logic [N:0]     div_diff;

  // One multiply or divide step, selected by mode.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' and give every output a default
    // first, so the block reads top-down and never infers a latch.
    mul_sum  = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, op_q} : '0);
    div_rem  = {acc_q[2*N-1:N], acc_q[N-1]};
    div_diff = div_rem - {1'b0, op_q};
    acc_d    = acc_q;
    case (mode)
      MODE_LOAD: acc_d = {{N{1'b0}}, load_a};
      MODE_MUL:  acc_d = {mul_sum, acc_q[N-1:1]};
      MODE_DIV:  acc_d = div_diff[N] ? {div_rem[N-1:0], acc_q[N-2:0], 1'b0}
                                     : {div_diff[N-1:0], acc_q[N-2:0], 1'b1};
      default:   acc_d = acc_q;
    endcase
  end

  // Accumulator and operand registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking '<=' so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      acc_q <= '0;
      op_q  <= '0;
    end else begin
      acc_q <= acc_d;
      if (mode == MODE_LOAD) op_q <= load_b;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit. Owns the FSM, step counter,
// operand sign handling, special-case divides and the result/rd registers.
module mul_div_unit
  import rv32m_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         Start_i,
  input  logic [2:0]   Funct3_i,
  input  logic [4:0]   Rd_i,
  input  logic [N-1:0] Operand_A_i,
  input  logic [N-1:0] Operand_B_i,
  output logic         Busy_o,
  output logic         Done_o,
  output logic [N-1:0] Result_o,
  output logic [4:0]   Rd_o
);

  localparam int           CW      = $clog2(N);
  localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

  state_t         state_q, state_d;
  core_mode_t     mode;
  logic [CW-1:0]  count_q;
  logic [2:0]     f3_q;
  logic [4:0]     rd_q;
  logic           neg_main_q, neg_rem_q, special_q;
  logic [N-1:0]   special_val_q, result_q;
  logic           accept, sign_a, sign_b, div_zero, div_ovf, special;
  logic [N-1:0]   mag_a, mag_b, special_val;
  logic [2*N-1:0] acc, prod_fix;
  logic [N-1:0]   quot_fix, rem_fix, result_fix;

  // Operand decode at accept: magnitudes, sign flags and special-case divides.
  always_comb begin
    accept   = Start_i && (state_q != RUN);
    sign_a   = is_signed(Funct3_i, 1'b0) && Operand_A_i[N-1];
    sign_b   = is_signed(Funct3_i, 1'b1) && Operand_B_i[N-1];
    mag_a    = sign_a ? -Operand_A_i : Operand_A_i;
    mag_b    = sign_b ? -Operand_B_i : Operand_B_i;
    div_zero = is_div(Funct3_i) && (Operand_B_i == '0);
    div_ovf  = ((Funct3_i == F3_DIV) || (Funct3_i == F3_REM)) &&
               (Operand_A_i == MIN_NEG) && (Operand_B_i == '1);
    special  = div_zero || div_ovf;
    // funct3[1] separates REM/REMU from DIV/DIVU.
    if (div_zero) special_val = Funct3_i[1] ? Operand_A_i : '1;
    else          special_val = Funct3_i[1] ? '0 : MIN_NEG;
  end

  // Next-state and shift-core mode; accept is possible from IDLE and DONE.
  always_comb begin
    state_d = state_q;
    mode    = MODE_HOLD;
    case (state_q)
      IDLE: begin
        if (Start_i) begin
          mode    = MODE_LOAD;
          state_d = special ? DONE : RUN;
        end
      end
      RUN: begin
        mode = is_div(f3_q) ? MODE_DIV : MODE_MUL;
        if (count_q == CW'(N - 1)) state_d = DONE;
      end
      DONE: begin
        if (Start_i) begin
          mode    = MODE_LOAD;
          state_d = special ? DONE : RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  mdu_shift_core #(.N(N)) u_core (
    .clk    (clk),
    .reset  (reset),
    .mode   (mode),
    .load_a (mag_a),
    .load_b (mag_b),
    .acc    (acc)
  );

  // Sign fix-up and result selection, meaningful while in DONE.
  always_comb begin
    prod_fix = neg_main_q ? -acc : acc;
    quot_fix = neg_main_q ? -acc[N-1:0] : acc[N-1:0];
    rem_fix  = neg_rem_q ? -acc[2*N-1:N] : acc[2*N-1:N];
    case (f3_q)
      F3_MUL:                      result_fix = prod_fix[N-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: result_fix = prod_fix[2*N-1:N];
      F3_DIV, F3_DIVU:             result_fix = quot_fix;
      default:                     result_fix = rem_fix;
    endcase
    if (special_q) result_fix = special_val_q;
  end

  // FSM state, counter, accept-time latches and the held result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      count_q       <= '0;
      f3_q          <= '0;
      rd_q          <= '0;
      neg_main_q    <= 1'b0;
      neg_rem_q     <= 1'b0;
      special_q     <= 1'b0;
      special_val_q <= '0;
      result_q      <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == RUN) begin
        count_q <= (count_q == CW'(N - 1)) ? '0 : count_q + CW'(1);
      end
      if (state_q == DONE) result_q <= result_fix;
      if (accept) begin
        count_q       <= '0;
        f3_q          <= Funct3_i;
        rd_q          <= Rd_i;
        neg_main_q    <= sign_a ^ sign_b;
        neg_rem_q     <= sign_a;
        special_q     <= special;
        special_val_q <= special_val;
      end
    end
  end

  assign Busy_o   = (state_q == RUN) || accept;
  assign Done_o   = (state_q == DONE);
  assign Result_o = Done_o ? result_fix : result_q;
  assign Rd_o     = rd_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: a behavioural RV32M model feeds an
// expectation queue; a single negedge process checks Busy/Done/Result/Rd each cycle.
module tb_mul_div_unit;
  import rv32m_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start_i;
  logic [2:0]  Funct3_i;
  logic [4:0]  Rd_i;
  logic [31:0] Operand_A_i, Operand_B_i;
  logic        Busy_o, Done_o;
  logic [31:0] Result_o;
  logic [4:0]  Rd_o;

  mul_div_unit #(.N(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .Start_i     (Start_i),
    .Funct3_i    (Funct3_i),
    .Rd_i        (Rd_i),
    .Operand_A_i (Operand_A_i),
    .Operand_B_i (Operand_B_i),
    .Busy_o      (Busy_o),
    .Done_o      (Done_o),
    .Result_o    (Result_o),
    .Rd_o        (Rd_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          done_cyc;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] last_res = '0;
  logic        busy_exp, done_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    else n_pass++;
  endtask

  // RV32M semantics straight from the ISA definition, using 64-bit arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    logic   ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'h0, a});
    ub  = longint'({32'h0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      F3_MUL:    begin p = ua * ub; return p[31:0];  end
      F3_MULH:   begin p = sa * sb; return p[63:32]; end
      F3_MULHSU: begin p = sa * ub; return p[63:32]; end
      F3_MULHU:  begin p = ua * ub; return p[63:32]; end
      F3_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        p = sa / sb; return p[31:0];
      end
      F3_DIVU: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      F3_REM: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  // Divide-by-zero and signed overflow finish one cycle after accept; all else after N+1.
  function automatic int latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic ovf;
    ovf = (f3 == F3_DIV || f3 == F3_REM) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    return (f3[2] && (b == 0 || ovf)) ? 1 : 33;
  endfunction

  function automatic exp_t make_exp(input logic [2:0] f3, input logic [4:0] rd,
                                    input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.res      = model(f3, a, b);
    e.rd       = rd;
    e.done_cyc = cyc + latency(f3, a, b);
    return e;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      q.delete();
      last_res = '0;
    end
  end

  // Cycle-by-cycle comparison against the expectation queue.
  always @(negedge clk) begin
    if (!reset) begin
      busy_exp = ((q.size() > 0) && (cyc < q[0].done_cyc)) || Start_i;
      done_exp = (q.size() > 0) && (cyc == q[0].done_cyc);
      check("busy", 32'(Busy_o), 32'(busy_exp));
      check("done", 32'(Done_o), 32'(done_exp));
      if (done_exp) begin
        check("result", Result_o, q[0].res);
        check("rd", 32'(Rd_o), 32'(q[0].rd));
        last_res = q[0].res;
        void'(q.pop_front());
      end else begin
        check("result_hold", Result_o, last_res);
      end
    end
  end

  // Drive one op for a single cycle; called just after a rising edge.
  task automatic issue(input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] hand);
    exp_t e;
    check("model_pin", model(f3, a, b), hand);
    e = make_exp(f3, rd, a, b);
    Start_i = 1'b1; Funct3_i = f3; Rd_i = rd; Operand_A_i = a; Operand_B_i = b;
    @(posedge clk);
    q.push_back(e);
    #1;
    Start_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    if (q.size() != 0) begin
      while (q.size() != 0 && n < 100) begin
        @(posedge clk);
        n++;
      end
      #1;
    end
    check("drain", 32'(q.size()), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    reset = 1'b1; Start_i = 1'b0; Funct3_i = '0; Rd_i = '0;
    Operand_A_i = '0; Operand_B_i = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_done", 32'(Done_o), 32'h0);
    check("rst_busy", 32'(Busy_o), 32'h0);
    check("rst_result", Result_o, 32'h0);
    check("rst_rd", 32'(Rd_o), 32'h0);
    @(posedge clk); #1;

    // Basic multiply, latency and busy window.
    issue(F3_MUL, 5'd5, 32'd7, 32'd6, 32'd42);                        wait_idle();
    issue(F3_MULH, 5'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);      wait_idle();
    issue(F3_MULHU, 5'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE); wait_idle();
    issue(F3_MULHSU, 5'd12, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);     wait_idle();
    issue(F3_MUL, 5'd13, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1);        wait_idle();
    issue(F3_MULH, 5'd14, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000); wait_idle();

    // Divides.
    issue(F3_DIV, 5'd15, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);        wait_idle();
    issue(F3_REM, 5'd16, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);        wait_idle();
    issue(F3_DIVU, 5'd17, 32'd100, 32'd7, 32'd14);                    wait_idle();
    issue(F3_REMU, 5'd18, 32'd100, 32'd7, 32'd2);                     wait_idle();
    issue(F3_DIV, 5'd19, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD);        wait_idle();
    issue(F3_REM, 5'd20, 32'd7, 32'hFFFF_FFFE, 32'd1);                wait_idle();

    // Special cases, back-to-back with no idle cycle between them.
    issue(F3_DIVU, 5'd1, 32'd5, 32'd0, 32'hFFFF_FFFF);
    issue(F3_REM, 5'd2, 32'd5, 32'd0, 32'd5);
    issue(F3_DIV, 5'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    issue(F3_REM, 5'd8, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
    wait_idle();

    // Reset at RUN cycle 10 aborts the op.
    issue(F3_DIVU, 5'd21, 32'd1000, 32'd3, 32'd333);
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort_done", 32'(Done_o), 32'h0);
    check("abort_busy", 32'(Busy_o), 32'h0);
    check("abort_result", Result_o, 32'h0);
    check("abort_rd", 32'(Rd_o), 32'h0);
    repeat (40) @(posedge clk);
    #1;
    issue(F3_MUL, 5'd22, 32'h0001_2345, 32'h0000_0100, 32'h0123_4500); wait_idle();

    // Start_i held through RUN and DONE: second op accepted in the DONE cycle.
    check("model_pin", model(F3_DIVU, 32'd100, 32'd7), 32'd14);
    e = make_exp(F3_MULHU, 5'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    Start_i = 1'b1; Funct3_i = F3_MULHU; Rd_i = 5'd3;
    Operand_A_i = 32'hFFFF_FFFF; Operand_B_i = 32'hFFFF_FFFF;
    @(posedge clk);
    q.push_back(e);
    #1;
    Funct3_i = F3_DIVU; Rd_i = 5'd4; Operand_A_i = 32'd100; Operand_B_i = 32'd7;
    repeat (32) @(posedge clk);
    #1;
    e = make_exp(F3_DIVU, 5'd4, 32'd100, 32'd7);
    @(posedge clk);
    q.push_back(e);
    #1;
    Start_i = 1'b0;
    wait_idle();

    // Start_i pulsed during RUN is ignored.
    issue(F3_DIV, 5'd9, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    repeat (4) @(posedge clk);
    #1;
    Start_i = 1'b1; Funct3_i = F3_MUL; Rd_i = 5'd30; Operand_A_i = 32'd3; Operand_B_i = 32'd3;
    @(posedge clk);
    #1 Start_i = 1'b0;
    wait_idle();

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
